// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions.
// Word size, reset vector and the fetch buffer entry layout.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch instruction buffer: ring buffer with flush.
// Push and pop may share a cycle even when full.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] CAP = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == CAP);
  assign count = r_count;
  assign rdata = r_mem[r_rptr];

  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case (1'b1)
        w_push && !w_pop: r_count <= r_count + CW'(1);
        w_pop && !w_push: r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only read when counted.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word fetches, tracks in-flight
// requests, drops stale responses after redirects, buffers the rest.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pcplus4
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outst;
  logic [CW-1:0]   r_discard;

  logic [CW-1:0]   w_outst_nxt;
  logic [CW-1:0]   w_buf_cnt;
  logic [CW:0]     w_occ;
  logic            w_full;
  logic            w_empty;
  logic            w_gnt;
  logic            w_keep;
  logic            w_drop;
  logic            w_pop;
  logic [XLEN-1:0] w_target;
  fetch_entry_t    w_wentry;
  fetch_entry_t    w_head;

  assign w_occ    = {1'b0, r_outst} + {1'b0, w_buf_cnt};
  assign w_target = word_align(redirect_pc);

  assign imem_req  = !reset && !redirect && !w_full
                   && (w_occ < CAP);
  assign imem_addr = r_pc;

  assign w_gnt  = imem_req && imem_gnt;
  assign w_drop = imem_rvalid && (r_discard != '0);
  assign w_keep = imem_rvalid && (r_discard == '0)
                && !redirect;
  assign w_pop  = instr_valid && instr_ready;

  always_comb begin
    w_outst_nxt = r_outst;
    unique case (1'b1)
      w_gnt && !imem_rvalid: w_outst_nxt = r_outst + CW'(1);
      imem_rvalid && !w_gnt: w_outst_nxt = r_outst - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_rsp_pc  <= RESET_PC;
      r_outst   <= '0;
      r_discard <= '0;
    end else begin
      r_outst <= w_outst_nxt;
      if (redirect) begin
        r_pc      <= w_target;
        r_rsp_pc  <= w_target;
        // Everything still in flight after this edge is stale.
        r_discard <= w_outst_nxt;
      end else begin
        if (w_gnt)  r_pc      <= r_pc + 32'd4;
        if (w_keep) r_rsp_pc  <= r_rsp_pc + 32'd4;
        if (w_drop) r_discard <= r_discard - CW'(1);
      end
    end
  end

  assign w_wentry.pc    = r_rsp_pc;
  assign w_wentry.instr = imem_rdata;

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (w_keep),
    .wdata (w_wentry),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_buf_cnt)
  );

  assign instr_valid   = !w_empty && !reset;
  assign instr         = w_head.instr;
  assign instr_pc      = w_head.pc;
  assign instr_pcplus4 = w_head.pc + 32'd4;

endmodule
